// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: instruction-memory req/ack bus plus decoder valid/ready bus
interface instr_fetch_unit_if #(parameter int ADDR_W = 64);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [31:0]       imem_rdata;
    logic [31:0]       instr;
    logic              instr_valid;
    logic              instr_ready;
    logic              BrTaken;
    logic              UncondBr;
    modport master (
        output imem_req, imem_addr, instr, instr_valid,
        input  imem_ack, imem_rdata, instr_ready, BrTaken, UncondBr
    );
    modport slave (
        input  imem_req, imem_addr, instr, instr_valid,
        output imem_ack, imem_rdata, instr_ready, BrTaken, UncondBr
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: owns the PC, fetches words over req/ack, issues them over valid/ready
module instr_fetch_unit #(
    parameter int                ADDR_W   = 64,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                CNT_W    = 32
) (
    input  logic               clk,
    input  logic               reset,
    instr_fetch_unit_if.master bus,
    output logic [ADDR_W-1:0]  pc,
    output logic [CNT_W-1:0]   retired
);
    typedef enum logic {REQ, ISSUE} state_t;
    state_t            state, state_n;
    logic              armed, fetch, accept;
    logic [ADDR_W-1:0] off;
    // armed keeps the request low for the first cycle after any reset edge
    assign bus.imem_req  = armed && state == REQ;
    assign bus.imem_addr = pc;
    assign fetch         = bus.imem_req && bus.imem_ack;
    assign accept        = bus.instr_valid && bus.instr_ready;
    always_comb begin
        state_n = fetch ? ISSUE : accept ? REQ : state;
        off     = !bus.BrTaken ? ADDR_W'(4) :
                  bus.UncondBr ? {{(ADDR_W-28){bus.instr[25]}}, bus.instr[25:0], 2'b00} :
                                 {{(ADDR_W-21){bus.instr[23]}}, bus.instr[23:5], 2'b00};
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= REQ;
            armed           <= 1'b0;
            pc              <= RESET_PC;
            bus.instr       <= '0;
            bus.instr_valid <= 1'b0;
            retired         <= '0;
        end else begin
            state <= state_n;
            armed <= 1'b1;
            if (fetch) begin
                bus.instr       <= bus.imem_rdata;
                bus.instr_valid <= 1'b1;
            end
            if (accept) begin
                bus.instr_valid <= 1'b0;
                retired         <= retired + CNT_W'(1);
                pc              <= pc + off;
            end
        end
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: scoreboard bench; stimulus queues expected fetch addresses and issued words
module tb_instr_fetch_unit;
    localparam int AW = 64;
    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] pc;
    logic [31:0]   retired;
    int            tests = 0;
    int            fails = 0;
    logic [AW-1:0]    addr_q[$];
    logic [AW+31:0]   iss_q[$];

    instr_fetch_unit_if #(.ADDR_W(AW)) bus();
    instr_fetch_unit #(.ADDR_W(AW), .RESET_PC(64'h0), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .bus(bus), .pc(pc), .retired(retired)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.imem_req && bus.imem_ack) begin
            if (addr_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_fetch: got addr %h, expected no fetch", bus.imem_addr);
            end else check("fetch_addr", bus.imem_addr, addr_q.pop_front());
        end
    end

    always @(negedge clk) begin
        logic [AW+31:0] e;
        if (bus.instr_valid && bus.instr_ready) begin
            if (iss_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_issue: got instr %h, expected none", bus.instr);
            end else begin
                e = iss_q.pop_front();
                check("issue_instr", 64'(bus.instr), 64'(e[31:0]));
                check("issue_pc", pc, e[AW+31:32]);
            end
        end
    end

    task automatic fetch(input logic [AW-1:0] a, input logic [31:0] w, input int waits,
                         input int stall, input logic br, input logic unc);
        int n = 0;
        addr_q.push_back(a);
        iss_q.push_back({a, w});
        while (!bus.imem_req && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.imem_req) begin
            tests++;
            fails++;
            $display("FAIL req_timeout: got imem_req=0 after %0d cycles, expected 1", n);
        end
        bus.instr_ready = 1'b1;
        for (int i = 0; i < waits; i++) begin
            bus.imem_ack   = 1'b0;
            bus.imem_rdata = $urandom;
            @(posedge clk); #1;
            check("wait_req", 64'(bus.imem_req), 64'(1));
            check("wait_addr", bus.imem_addr, a);
        end
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = w;
        @(posedge clk); #1;
        bus.imem_rdata = ~w;
        bus.instr_ready = 1'b0;
        check("valid_latency", 64'(bus.instr_valid), 64'(1));
        for (int i = 0; i < stall; i++) begin
            bus.BrTaken  = i[0] ? br : ~br;
            bus.UncondBr = ~unc;
            bus.imem_ack = 1'b1;
            @(posedge clk); #1;
            check("stall_instr", 64'(bus.instr), 64'(w));
            check("stall_pc", pc, a);
            check("stall_valid", 64'(bus.instr_valid), 64'(1));
            check("stall_req", 64'(bus.imem_req), 64'(0));
        end
        bus.imem_ack    = 1'b0;
        bus.instr_ready = 1'b1;
        bus.BrTaken     = br;
        bus.UncondBr    = unc;
        @(posedge clk); #1;
        bus.instr_ready = 1'b0;
        bus.BrTaken     = ~br;
        bus.UncondBr    = ~unc;
        check("valid_drop", 64'(bus.instr_valid), 64'(0));
    endtask

    initial begin
        bus.imem_ack    = 1'b0;
        bus.imem_rdata  = '0;
        bus.instr_ready = 1'b0;
        bus.BrTaken     = 1'b0;
        bus.UncondBr    = 1'b0;
        reset           = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            check("rst_pc", pc, 64'h0);
            check("rst_req", 64'(bus.imem_req), 64'(0));
            check("rst_addr", bus.imem_addr, 64'h0);
            check("rst_valid", 64'(bus.instr_valid), 64'(0));
            check("rst_instr", 64'(bus.instr), 64'(0));
            check("rst_retired", 64'(retired), 64'(0));
        end
        reset = 1'b0;
        fetch(64'h0, 32'h8B020020, 0, 0, 1'b0, 1'b0);
        fetch(64'h4, 32'h8B030041, 0, 0, 1'b0, 1'b1);
        fetch(64'h8, 32'hF8400062, 0, 0, 1'b0, 1'b0);
        fetch(64'hC, 32'hCB040083, 0, 0, 1'b0, 1'b0);
        check("retired_4", 64'(retired), 64'(4));
        fetch(64'h10, 32'h17FFFFFE, 3, 0, 1'b1, 1'b1);
        fetch(64'h8, 32'h17FFFFFE, 0, 0, 1'b1, 1'b1);
        fetch(64'h0, 32'h17FFFFFF, 0, 0, 1'b1, 1'b1);
        fetch(64'hFFFF_FFFF_FFFF_FFFC, 32'hB4000120, 1, 0, 1'b1, 1'b0);
        fetch(64'h20, 32'hB4000060, 0, 0, 1'b1, 1'b0);
        fetch(64'h2C, 32'hB4000060, 0, 5, 1'b0, 1'b1);
        fetch(64'h30, 32'h17FFFFFE, 2, 4, 1'b1, 1'b1);
        check("retired_11", 64'(retired), 64'(11));
        bus.imem_ack = 1'b0;
        @(posedge clk); #1;
        check("mid_req", 64'(bus.imem_req), 64'(1));
        check("mid_addr", bus.imem_addr, 64'h28);
        reset = 1'b1;
        @(posedge clk); #1;
        reset          = 1'b0;
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'hDEADBEEF;
        check("mid_rst_pc", pc, 64'h0);
        check("mid_rst_valid", 64'(bus.instr_valid), 64'(0));
        check("mid_rst_retired", 64'(retired), 64'(0));
        check("mid_rst_req", 64'(bus.imem_req), 64'(0));
        @(posedge clk); #1;
        bus.imem_ack = 1'b0;
        check("late_ack_valid", 64'(bus.instr_valid), 64'(0));
        check("late_ack_instr", 64'(bus.instr), 64'(0));
        check("restart_req", 64'(bus.imem_req), 64'(1));
        check("restart_addr", bus.imem_addr, 64'h0);
        fetch(64'h0, 32'h8B000000, 1, 0, 1'b0, 1'b0);
        check("retired_after_rst", 64'(retired), 64'(1));
        check("restart_next_addr", bus.imem_addr, 64'h4);
        check("addr_q_drained", 64'(addr_q.size()), 64'(0));
        check("iss_q_drained", 64'(iss_q.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, expected finish before 200000");
        $fatal(1, "watchdog");
    end
endmodule
